// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vector_mem_sequencer                                        |
// | Brief    : Splits one vector load/store into LANES word accesses.      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module vector_mem_sequencer #(
   parameter int LANES         = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [ADDRESS_WIDTH-1:0]      req_base,
   input  logic [ADDRESS_WIDTH-1:0]      req_stride,
   input  logic [LANES*DATA_WIDTH-1:0]   req_wdata,
   output logic                          resp_valid,
   output logic [LANES*DATA_WIDTH-1:0]   resp_rdata,
   output logic                          mem_write_enable,
   output logic [ADDRESS_WIDTH-1:0]      mem_read_address,
   output logic [ADDRESS_WIDTH-1:0]      mem_write_address,
   output logic [DATA_WIDTH-1:0]         mem_input_data,
   input  logic [DATA_WIDTH-1:0]         mem_output_data
);

   localparam int                 c_IDX_W     = $clog2(LANES);
   localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [c_IDX_W-1:0]            r_lane_idx;
   logic [ADDRESS_WIDTH-1:0]      r_cur_addr;
   logic [ADDRESS_WIDTH-1:0]      r_stride;
   logic [LANES*DATA_WIDTH-1:0]   r_wdata;
   logic [LANES*DATA_WIDTH-1:0]   r_rdata;
   logic                          w_accept;
   logic                          w_last_lane;
   logic [DATA_WIDTH-1:0]         w_store_word;

   assign w_last_lane = (r_lane_idx == c_LAST_LANE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = req_write ? S_STORE : S_LOAD;
            end
         end
         S_LOAD, S_STORE: begin
            if (w_last_lane) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            resp_valid  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Lane address is a running sum, so wrap-around falls out of the adder width.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lane_idx <= '0;
         r_cur_addr <= '0;
         r_stride   <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         if (w_accept) begin
            r_lane_idx <= '0;
            r_cur_addr <= req_base;
            r_stride   <= req_stride;
            r_wdata    <= req_wdata;
         end else if (r_state == S_LOAD || r_state == S_STORE) begin
            r_lane_idx <= r_lane_idx + 1'b1;
            r_cur_addr <= r_cur_addr + r_stride;
            if (r_state == S_LOAD) begin
               for (int i = 0; i < LANES; i++) begin
                  if (r_lane_idx == c_IDX_W'(i)) begin
                     r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem_output_data;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      w_store_word = r_wdata[DATA_WIDTH-1:0];
      if (r_state == S_STORE) begin
         for (int i = 0; i < LANES; i++) begin
            if (r_lane_idx == c_IDX_W'(i)) begin
               w_store_word = r_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Gated by reset so a store in flight never commits during the reset cycle.
   assign mem_write_enable  = (r_state == S_STORE) & ~reset;
   assign mem_read_address  = r_cur_addr;
   assign mem_write_address = r_cur_addr;
   assign mem_input_data    = w_store_word;
   assign resp_rdata        = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_vector_mem_sequencer                                     |
// | Brief    : Scoreboard bench with a word-addressed memory model.        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_vector_mem_sequencer;

   localparam int LANES = 4;
   localparam int DW    = 32;
   localparam int AW    = 32;

   localparam logic [DW-1:0] c_A  = 32'h1111_AAAA;
   localparam logic [DW-1:0] c_B  = 32'h2222_BBBB;
   localparam logic [DW-1:0] c_C  = 32'h3333_CCCC;
   localparam logic [DW-1:0] c_D  = 32'h4444_DDDD;
   localparam logic [DW-1:0] c_E1 = 32'hE1E1_0001;
   localparam logic [DW-1:0] c_E2 = 32'hE1E1_0002;
   localparam logic [DW-1:0] c_E3 = 32'hE1E1_0003;
   localparam logic [DW-1:0] c_E4 = 32'hE1E1_0004;

   logic                   clk       = 1'b0;
   logic                   reset     = 1'b1;
   logic                   tb_init   = 1'b1;
   logic                   req_valid = 1'b0;
   logic                   req_write = 1'b0;
   logic [AW-1:0]          req_base  = '0;
   logic [AW-1:0]          req_stride = '0;
   logic [LANES*DW-1:0]    req_wdata = '0;
   logic                   req_ready;
   logic                   resp_valid;
   logic [LANES*DW-1:0]    resp_rdata;
   logic                   mem_write_enable;
   logic [AW-1:0]          mem_read_address;
   logic [AW-1:0]          mem_write_address;
   logic [DW-1:0]          mem_input_data;
   logic [DW-1:0]          mem_output_data;

   logic [DW-1:0]          ram [256];
   logic [LANES*DW-1:0]    exp_resp_q [$];
   logic [AW+DW-1:0]       exp_wr_q [$];
   logic [LANES*DW-1:0]    last_rdata = '0;
   int                     n_vec = 0;
   int                     n_err = 0;

   vector_mem_sequencer #(
      .LANES         (LANES),
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_base          (req_base),
      .req_stride        (req_stride),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .mem_write_enable  (mem_write_enable),
      .mem_read_address  (mem_read_address),
      .mem_write_address (mem_write_address),
      .mem_input_data    (mem_input_data),
      .mem_output_data   (mem_output_data)
   );

   always #5 clk = ~clk;

   // Only the bottom and top 256 words exist; any other address reads a poison value.
   assign mem_output_data = (mem_read_address[31:8] == 24'h0 || mem_read_address[31:8] == 24'hFF_FFFF)
                            ? ram[mem_read_address[7:0]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
         ram[16]   <= c_A;
         ram[17]   <= c_B;
         ram[18]   <= c_C;
         ram[19]   <= c_D;
         ram[8'hFE] <= c_E1;
         ram[8'hFF] <= c_E2;
         ram[8'h00] <= c_E3;
         ram[8'h01] <= c_E4;
      end else if (mem_write_enable) begin
         ram[mem_write_address[7:0]] <= mem_input_data;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_resp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response", resp_rdata);
         end else begin
            check("resp_rdata", resp_rdata, exp_resp_q.pop_front());
         end
      end
      if (mem_write_enable) begin
         if (exp_wr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                     mem_write_address, mem_input_data);
         end else begin
            check("mem_write", {mem_write_address, mem_input_data}, exp_wr_q.pop_front());
         end
      end
   end

   task automatic do_req(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [LANES*DW-1:0] wdata, input bit hold);
      int waited = 0;
      req_valid  = 1'b1;
      req_write  = wr;
      req_base   = base;
      req_stride = stride;
      req_wdata  = wdata;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", 128'(req_ready), 128'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      for (int k = 1; k <= LANES + 2; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) req_valid = 1'b0;
         if (k == 1 && hold) begin
            req_write = 1'b1;
            req_base  = 32'h0000_00A0;
            req_wdata = {4{32'hBAD0_BAD0}};
         end
         if (k == LANES + 1) req_valid = 1'b0;
         if (k <= LANES)          check("busy_handshake", 128'({resp_valid, req_ready}), 128'b00);
         else if (k == LANES + 1) check("done_handshake", 128'({resp_valid, req_ready}), 128'b10);
         else                     check("idle_handshake", 128'({resp_valid, req_ready}), 128'b01);
      end
   endtask

   task automatic expect_load(input logic [LANES*DW-1:0] v);
      exp_resp_q.push_back(v);
      last_rdata = v;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      tb_init = 1'b0;
      reset   = 1'b0;
      check("reset_req_ready",  128'(req_ready), 128'd1);
      check("reset_resp_valid", 128'(resp_valid), 128'd0);
      check("reset_resp_rdata", 128'(resp_rdata), 128'd0);
      check("reset_mem_we",     128'(mem_write_enable), 128'd0);

      // Unit-stride load
      expect_load({c_D, c_C, c_B, c_A});
      do_req(1'b0, 32'd16, 32'd1, '0, 1'b0);

      // Strided store; rdata untouched
      exp_wr_q.push_back({32'd100, 32'd1});
      exp_wr_q.push_back({32'd104, 32'd2});
      exp_wr_q.push_back({32'd108, 32'd3});
      exp_wr_q.push_back({32'd112, 32'd4});
      exp_resp_q.push_back(last_rdata);
      do_req(1'b1, 32'd100, 32'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);

      // Read back what was just stored
      expect_load({32'd4, 32'd3, 32'd2, 32'd1});
      do_req(1'b0, 32'd100, 32'd4, '0, 1'b0);

      // Address wrap, with req_valid held high through the busy cycles
      expect_load({c_E4, c_E3, c_E2, c_E1});
      do_req(1'b0, 32'hFFFF_FFFE, 32'd1, '0, 1'b1);

      // Stride 0 store: last lane wins
      exp_wr_q.push_back({32'd50, 32'd6});
      exp_wr_q.push_back({32'd50, 32'd7});
      exp_wr_q.push_back({32'd50, 32'd8});
      exp_wr_q.push_back({32'd50, 32'd9});
      exp_resp_q.push_back(last_rdata);
      do_req(1'b1, 32'd50, 32'd0, {32'd9, 32'd8, 32'd7, 32'd6}, 1'b0);

      expect_load({32'd9, 32'd9, 32'd9, 32'd9});
      do_req(1'b0, 32'd50, 32'd0, '0, 1'b0);

      // Negative stride via wrap
      expect_load({c_A, c_B, c_C, c_D});
      do_req(1'b0, 32'd19, 32'hFFFF_FFFF, '0, 1'b0);

      // Reset during lane 1 of a store
      exp_wr_q.push_back({32'd70, 32'h11});
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_base   = 32'd70;
      req_stride = 32'd1;
      req_wdata  = {32'h44, 32'h33, 32'h22, 32'h11};
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("reset_blocks_write", 128'(mem_write_enable), 128'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      check("post_reset_ready", 128'({resp_valid, req_ready}), 128'b01);
      check("post_reset_rdata", 128'(resp_rdata), 128'd0);

      // Only lane 0 of the aborted store may have landed
      expect_load({32'd0, 32'd0, 32'd0, 32'h11});
      do_req(1'b0, 32'd70, 32'd1, '0, 1'b0);

      repeat (4) @(negedge clk);
      check("resp_queue_drained",  128'(exp_resp_q.size()), 128'd0);
      check("write_queue_drained", 128'(exp_wr_q.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 expected finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
